// File: rtl/meta_packet_gen.sv
// meta_packet_gen: AXI4-Stream metadata packet generator (header, payload, optional trailer).
// Define META_CHECKSUM_EN to append an XOR checksum trailer beat to every packet.
module meta_packet_gen #(
    parameter int unsigned DW        = 128,
    parameter int unsigned PKT_BEATS = 4,
    parameter int unsigned NCH       = 4,
    parameter logic [15:0] MAGIC     = 16'h0666
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          continuous,
    input  logic [31:0]   payload_seed,
    output logic [DW-1:0] axis_out_tdata,
    output logic          axis_out_tvalid,
    input  logic          axis_out_tready,
    output logic          axis_out_tlast,
    output logic [3:0]    axis_out_tdest,
    output logic          busy,
    output logic [31:0]   pkt_count
);
`ifdef META_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, HDR, PAY, TRL} state_e;
    localparam logic LAST_ON_PAY = 1'b0;
`else
    typedef enum logic [1:0] {IDLE, HDR, PAY} state_e;
    localparam logic LAST_ON_PAY = 1'b1;
`endif
    localparam logic [7:0] LAST_K = 8'(PKT_BEATS);
    localparam logic [3:0] LAST_CH = 4'(NCH - 1);

    state_e        state_q;
    logic [7:0]    beat_q;
    logic [31:0]   seed_q;
    logic [31:0]   seq_q;
    logic [3:0]    ch_q;
    logic [31:0]   cnt_q;
    logic [DW-1:0] tdata_q;
    logic          tvalid_q;
    logic          tlast_q;
    logic [3:0]    tdest_q;
    logic          busy_q;
`ifdef META_CHECKSUM_EN
    logic [DW-1:0] csum_q;
`endif

    logic        hs, done, load;
    logic [3:0]  ch_d;
    logic [31:0] seq_d, cnt_d;
    logic [7:0]  k_d;

    function automatic logic [DW-1:0] hdr_f(input logic [3:0] ch, input logic [31:0] seq);
        logic [DW-1:0] h;
        h = '0;
        h[15:0]  = MAGIC;
        h[23:16] = {4'b0, ch};
        h[31:24] = LAST_K;
        h[63:32] = seq;
        return h;
    endfunction

    function automatic logic [DW-1:0] pay_f(input logic [31:0] seed, input logic [7:0] k);
        logic [DW-1:0] p;
        p = '0;
        p[31:0]  = seed + {24'b0, k};
        p[39:32] = k;
        return p;
    endfunction

    // Completion bookkeeping is computed up front so a back-to-back header
    // already carries the advanced channel and sequence number.
    always_comb begin
        hs    = tvalid_q & axis_out_tready;
        done  = hs & tlast_q;
        load  = ((state_q == IDLE) & (start | continuous)) | (done & continuous);
        ch_d  = ch_q;
        seq_d = seq_q;
        cnt_d = cnt_q;
        if (done) begin
            ch_d  = (ch_q == LAST_CH) ? 4'd0 : ch_q + 4'd1;
            seq_d = seq_q + 32'd1;
            cnt_d = cnt_q + 32'd1;
        end
        k_d = beat_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            seed_q   <= '0;
            seq_q    <= '0;
            ch_q     <= '0;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdest_q  <= '0;
            busy_q   <= 1'b0;
`ifdef META_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            ch_q  <= ch_d;
            seq_q <= seq_d;
            cnt_q <= cnt_d;
            if (load) begin
                state_q  <= HDR;
                busy_q   <= 1'b1;
                tvalid_q <= 1'b1;
                tlast_q  <= 1'b0;
                tdest_q  <= ch_d;
                tdata_q  <= hdr_f(ch_d, seq_d);
                seed_q   <= payload_seed;
`ifdef META_CHECKSUM_EN
                csum_q   <= '0;
`endif
            end else if (done) begin
                state_q  <= IDLE;
                busy_q   <= 1'b0;
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                tdata_q  <= '0;
            end else if (hs) begin
`ifdef META_CHECKSUM_EN
                csum_q <= csum_q ^ tdata_q;
`endif
                unique case (state_q)
                    HDR: begin
                        state_q <= PAY;
                        beat_q  <= 8'd1;
                        tdata_q <= pay_f(seed_q, 8'd1);
                        tlast_q <= LAST_ON_PAY & (LAST_K == 8'd1);
                    end
                    PAY: begin
`ifdef META_CHECKSUM_EN
                        if (beat_q == LAST_K) begin
                            state_q <= TRL;
                            tdata_q <= csum_q ^ tdata_q;
                            tlast_q <= 1'b1;
                        end else begin
                            beat_q  <= k_d;
                            tdata_q <= pay_f(seed_q, k_d);
                            tlast_q <= LAST_ON_PAY & (k_d == LAST_K);
                        end
`else
                        beat_q  <= k_d;
                        tdata_q <= pay_f(seed_q, k_d);
                        tlast_q <= LAST_ON_PAY & (k_d == LAST_K);
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign axis_out_tdata  = tdata_q;
    assign axis_out_tvalid = tvalid_q;
    assign axis_out_tlast  = tlast_q;
    assign axis_out_tdest  = tdest_q;
    assign busy            = busy_q;
    assign pkt_count       = cnt_q;
endmodule

// File: doc/meta_packet_gen.md
# meta_packet_gen

Parametrised AXI4-Stream metadata packet generator for the capture datapath. On a start request it emits framed packets: one header beat, `PKT_BEATS` payload beats and an optional checksum trailer. It carries per-packet channel IDs, a sequence number and full `tready` back-pressure. It sits ahead of the stream mux and drives meta traffic alongside the sample streams.

## Interface
Parameters:
- `DW`, 128: stream data width; legal range 64..512, multiple of 32.
- `PKT_BEATS`, 4: payload beats per packet; legal range 1..255.
- `NCH`, 4: number of channel IDs rotated round-robin; legal range 1..16.
- `MAGIC`, 16'h0666: header signature constant.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  synchronous, active-low reset.
- `start`  in  1  request one packet; sampled only in IDLE.
- `continuous`  in  1  when 1, a new packet follows immediately after each packet.
- `payload_seed`  in  32  base value for payload words; captured when the header is loaded.
- `axis_out_tdata`  out  DW  stream data.
- `axis_out_tvalid`  out  1  stream valid.
- `axis_out_tready`  in  1  stream ready.
- `axis_out_tlast`  out  1  marks the final beat of a packet.
- `axis_out_tdest`  out  4  channel ID of the current packet.
- `busy`  out  1  high when the state is not IDLE.
- `pkt_count`  out  32  number of completed packets (tlast handshakes); wraps at 2^32.

## Operation
- **States:**
  - IDLE: wait for a request.
  - HDR: present the header beat.
  - PAY: present payload beats k = 1..PKT_BEATS.
  - TRL: present the checksum trailer; exists only with the macro below.
- **Transitions:**
  - IDLE -> HDR when `start` = 1 or `continuous` = 1.
  - HDR -> PAY on handshake.
  - PAY beat k -> beat k+1 on handshake.
  - Last PAY beat (handshake):
    - -> TRL with the macro.
    - Otherwise -> HDR if `continuous` = 1, else IDLE.
  - TRL (handshake) -> HDR if `continuous` = 1, else IDLE.
- **Handshake:** a beat transfers when `tvalid` && `tready`.
- **Header beat layout:**
  - [15:0] = MAGIC
  - [23:16] = channel ID, zero-extended
  - [31:24] = PKT_BEATS
  - [63:32] = sequence number
  - [DW-1:64] = 0
- **Payload beat k layout:**
  - [31:0] = captured seed + k, modulo 2^32
  - [39:32] = k
  - all higher bits = 0
- **Packet completion (tlast handshake):**
  - Channel ID advances: 0, 1, …, NCH-1, 0.
  - Sequence number increments and wraps at 2^32.
  - `pkt_count` increments.
- `start` while `busy` is ignored; it is not queued.
- `continuous` is sampled at the final beat's handshake. Deasserting it mid-packet lets the current packet finish, then the block returns to IDLE.
- `axis_out_tdest` equals the packet's channel ID for every beat of that packet.

## Timing
- Reset values:
  - `tvalid`, `tlast`, `busy` = 0
  - `tdata` = 0, `tdest` = 0, `pkt_count` = 0
  - internal sequence = 0, channel = 0
- All outputs are registered.
- Latency: `start` high at edge N in IDLE -> header valid after edge N (visible in cycle N+1).
- Throughput: one beat per cycle while `tready` = 1, with no bubbles inside a packet or between back-to-back packets in continuous mode.
- While `tvalid` = 1 and `tready` = 0, `tdata`, `tlast` and `tdest` hold stable. `tvalid` never drops without a handshake, except on reset.
- `tlast` is high only on the final beat: the last payload beat, or the trailer when the macro is defined.
- Reset asserted mid-packet: all outputs take their reset values at that edge. The packet is truncated with no tlast, and the next packet restarts at sequence 0, channel 0.
- Sequence number 32'hFFFFFFFF is followed by 0.
- With NCH = 1, the channel ID is always 0.

## Configuration
- `META_CHECKSUM_EN`:
  - Defined: each packet carries one extra TRL beat equal to the bitwise XOR of all preceding DW-wide beats of that packet (header plus payloads). Packet length is PKT_BEATS + 2.
  - Undefined: no TRL state, no XOR accumulator, and packet length is PKT_BEATS + 1.

## Test plan
All scenarios use the default parameters (DW=128, PKT_BEATS=4, NCH=4).
1. **Basic packet:** reset, then one `start` pulse, `tready` = 1, seed = 0x100. Required:
   - Header [15:0] = 0x0666, ch = 0, [31:24] = 4, seq = 0.
   - Payload [31:0] = 0x101, 0x102, 0x103, 0x104.
   - `tlast` only on the 5th beat, `tvalid` = 0 on the next cycle, `pkt_count` = 1.
2. **Back-pressure:** same stimulus with `tready` toggling 1/0 every cycle. Required: identical beat sequence, and data/`tlast` stable on every stalled cycle.
3. **Continuous mode:** `continuous` = 1 for 5 packets. Required:
   - `tdest` = 0, 1, 2, 3, 0 and seq = 0..4.
   - Each header appears in the cycle immediately after the previous tlast handshake.
   - `pkt_count` = 5.
4. **Start while busy:** `start` reasserted during payload beat 2. Required: ignored, exactly one packet, `pkt_count` = 1, `busy` = 0 afterwards.
5. **Reset mid-packet:** `resetn` = 0 during payload beat 2. Required:
   - `tvalid` = 0 after that edge and `pkt_count` = 0.
   - The next `start` yields ch = 0, seq = 0.
6. **Checksum (`META_CHECKSUM_EN`), seed = 0:** Required:
   - The 6th beat equals the XOR of the header and the four payload beats: [15:0] = 0x0666^4, [31:24] = 4, [39:32] = 4, all other bits 0.
   - `tlast` on beat 6 only.
